// File: rtl/vec_stepper.sv
// Multi-component accumulator that adds a latched signed step vector for a programmed number of cycles.
// Build option: define VEC_STEPPER_SAT_EN to clamp overflowing components instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start with a non-zero count
// RUN   | adding steps each non-halted cycle, counting down
// DONE  | one-cycle completion pulse, then back to IDLE
module vec_stepper #(
    parameter int NCOMP = 2,
    parameter int CW    = 16,
    parameter int NW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NCOMP*CW-1:0]   step_in,
    input  logic [NW-1:0]         count,
    input  logic                  halt,
    input  logic                  clr,
    output logic [NCOMP*CW-1:0]   result,
    output logic                  busy,
    output logic                  done,
    output logic [NCOMP-1:0]      ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NCOMP-1:0][CW-1:0] acc;
    logic [NCOMP-1:0][CW-1:0] step;
    logic [NCOMP-1:0][CW-1:0] raw;
    logic [NCOMP-1:0][CW-1:0] sum;
    logic [NCOMP-1:0]         ovf_r;
    logic [NCOMP-1:0]         ovf_now;
    logic [NW-1:0]            rem;
    logic                     accept;
    logic                     advance;

    assign accept  = (state == IDLE) && start && (count != '0);
    assign advance = (state == RUN) && !halt;

    // Packed index j maps straight onto result/ovf bit positions, so component 0 is index NCOMP-1.
    always_comb begin
        raw     = '0;
        sum     = '0;
        ovf_now = '0;
        for (int j = 0; j < NCOMP; j++) begin
            raw[j]     = acc[j] + step[j];
            ovf_now[j] = (acc[j][CW-1] == step[j][CW-1]) && (raw[j][CW-1] != acc[j][CW-1]);
`ifdef VEC_STEPPER_SAT_EN
            if (ovf_now[j])
                sum[j] = acc[j][CW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
            else
                sum[j] = raw[j];
`else
            sum[j] = raw[j];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = RUN;
                RUN:     if (advance && (rem == NW'(1))) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            step  <= '0;
            ovf_r <= '0;
            rem   <= '0;
        end else if (clr) begin
            acc   <= '0;
            ovf_r <= '0;
            rem   <= '0;
        end else if (accept) begin
            step  <= step_in;
            rem   <= count;
            ovf_r <= '0;
        end else if (advance) begin
            acc   <= sum;
            ovf_r <= ovf_r | ovf_now;
            rem   <= rem - NW'(1);
        end
    end

    assign result = acc;
    assign ovf    = ovf_r;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_vec_stepper.sv
// Directed bench for vec_stepper: default 2x16 instance plus a 4x8 instance.
module tb_vec_stepper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] step_in = '0;
    logic [15:0] count = '0;
    logic        halt = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [1:0]  ovf;

    logic        start4 = 1'b0;
    logic [31:0] step4 = '0;
    logic [15:0] count4 = '0;
    logic        halt4 = 1'b0;
    logic        clr4 = 1'b0;
    logic [31:0] result4;
    logic        busy4;
    logic        done4;
    logic [3:0]  ovf4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_stepper dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_in(step_in), .count(count),
        .halt(halt), .clr(clr), .result(result), .busy(busy), .done(done), .ovf(ovf)
    );

    vec_stepper #(.NCOMP(4), .CW(8), .NW(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .step_in(step4), .count(count4),
        .halt(halt4), .clr(clr4), .result(result4), .busy(busy4), .done(done4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a run, optionally halting for hlen cycles from RUN cycle hfrom, and check its length and done pulse.
    task automatic do_run(input string tag, input logic [31:0] s, input logic [15:0] n,
                          input int hfrom, input int hlen, input int exp_runs);
        int runs;
        bit seen;
        runs = 0;
        seen = 0;
        @(negedge clk);
        start = 1'b1; step_in = s; count = n;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (busy) runs++;
            if (done) begin
                seen = 1;
                break;
            end
            halt = (c >= hfrom) && (c < hfrom + hlen);
            @(negedge clk);
        end
        halt = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_run_cycles"}, 64'(runs), 64'(exp_runs));
        @(negedge clk);
        chk({tag, "_done_single"}, 64'(done), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run("basic", {16'd1, 16'd3}, 16'd4, 0, 0, 4);
        chk("basic_result", 64'(result), 64'h0004_000C);

        do_run("halt", {16'd1, 16'd3}, 16'd4, 1, 3, 7);
        chk("halt_result", 64'(result), 64'h0008_0018);

        @(negedge clk);
        start = 1'b1; step_in = {16'd9, 16'd9}; count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("cnt0_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("cnt0_busy2", 64'(busy), 64'd0);
        chk("cnt0_result", 64'(result), 64'h0008_0018);

        pulse_clr();
        chk("clr_result", 64'(result), 64'd0);

        do_run("pre_ovf", {16'h7FFE, 16'h0000}, 16'd1, 0, 0, 1);
        chk("pre_ovf_result", 64'(result), 64'h7FFE_0000);
        chk("pre_ovf_flag", 64'(ovf), 64'd0);
        do_run("pos_ovf", {16'h0003, 16'h0000}, 16'd1, 0, 0, 1);
`ifdef VEC_STEPPER_SAT_EN
        chk("pos_ovf_result", 64'(result), 64'h7FFF_0000);
`else
        chk("pos_ovf_result", 64'(result), 64'h8001_0000);
`endif
        chk("pos_ovf_flag", 64'(ovf), 64'b10);
        do_run("after_ovf", {16'h0001, 16'h0000}, 16'd1, 0, 0, 1);
`ifdef VEC_STEPPER_SAT_EN
        chk("after_ovf_result", 64'(result), 64'h7FFF_0000);
        chk("after_ovf_flag", 64'(ovf), 64'b10);
`else
        chk("after_ovf_result", 64'(result), 64'h8002_0000);
        chk("after_ovf_flag", 64'(ovf), 64'b00);
`endif

        pulse_clr();
        chk("clr_ovf", 64'(ovf), 64'd0);
        do_run("neg_pre", {16'h0000, 16'h8000}, 16'd1, 0, 0, 1);
        chk("neg_pre_flag", 64'(ovf), 64'd0);
        do_run("neg_ovf", {16'h0000, 16'hFFFF}, 16'd1, 0, 0, 1);
`ifdef VEC_STEPPER_SAT_EN
        chk("neg_ovf_result", 64'(result), 64'h0000_8000);
`else
        chk("neg_ovf_result", 64'(result), 64'h0000_7FFF);
`endif
        chk("neg_ovf_flag", 64'(ovf), 64'b01);

        // clr on the final RUN cycle wins over completion
        pulse_clr();
        @(negedge clk);
        start = 1'b1; step_in = {16'd1, 16'd1}; count = 16'd2;
        @(negedge clk);
        start = 1'b0;
        chk("clrlast_busy", 64'(busy), 64'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clrlast_done", 64'(done), 64'd0);
        chk("clrlast_busy2", 64'(busy), 64'd0);
        chk("clrlast_result", 64'(result), 64'd0);
        @(negedge clk);
        chk("clrlast_done2", 64'(done), 64'd0);

        // start held through RUN and DONE with different operands must be ignored
        start = 1'b1; step_in = {16'd1, 16'd1}; count = 16'd3;
        @(negedge clk);
        step_in = {16'd5, 16'd5}; count = 16'd1;
        chk("hold_busy1", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("hold_busy3", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        chk("hold_done", 64'(done), 64'd1);
        chk("hold_result", 64'(result), 64'h0003_0003);

        // async reset between edges mid-run
        @(negedge clk);
        start = 1'b1; step_in = {16'd1, 16'd1}; count = 16'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_result", 64'(result), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("async_noresume_busy", 64'(busy), 64'd0);
        chk("async_noresume_result", 64'(result), 64'd0);

        // 4x8 instance, same shape of run
        start4 = 1'b1; step4 = {8'd1, 8'd2, 8'hFF, 8'd3}; count4 = 16'd4;
        @(negedge clk);
        start4 = 1'b0;
        begin
            int runs4;
            bit seen4;
            runs4 = 0;
            seen4 = 0;
            for (int c = 0; c < 50; c++) begin
                if (busy4) runs4++;
                if (done4) begin
                    seen4 = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("n4_done_seen", 64'(seen4), 64'd1);
            chk("n4_run_cycles", 64'(runs4), 64'd4);
        end
        chk("n4_result", 64'(result4), 64'h0408_FC0C);
        chk("n4_ovf", 64'(ovf4), 64'd0);
        @(negedge clk);
        chk("n4_done_single", 64'(done4), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_stepper.md
VEC_STEPPER -- requirements
Module: vec_stepper

Interface
REQ-001 SHALL have parameter NCOMP, default 2: number of vector components (1..8).
REQ-002 SHALL have parameter CW, default 16: width of each component in bits (2..32).
REQ-003 SHALL have parameter NW, default 16: width of the step-count field.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1: request a run; accepted only in IDLE.
REQ-007 SHALL have port step_in  input  NCOMP*CW: per-component signed step, sampled when start is accepted.
REQ-008 SHALL have port count  input  NW: number of steps to apply, sampled when start is accepted.
REQ-009 SHALL have port halt  input  1: freezes accumulation while in RUN.
REQ-010 SHALL have port clr  input  1: synchronous clear and abort.
REQ-011 SHALL have port result  output  NCOMP*CW: packed accumulators; component 0 occupies the MSBs.
REQ-012 SHALL have port busy  output  1: high in RUN.
REQ-013 SHALL have port done  output  1: single-cycle pulse when a run completes.
REQ-014 SHALL have port ovf  output  NCOMP: sticky per-component overflow flag.

Function
REQ-015 SHALL implement the states IDLE, RUN and DONE.
REQ-016 IDLE: start=1 and count!=0 SHALL latch step_in and count, clear ovf, and enter RUN on the next cycle; start with count=0 SHALL be ignored.
REQ-017 RUN with halt=0 SHALL, each cycle, add each latched step (two's complement, CW bits) to its accumulator and decrement the remaining count.
REQ-018 RUN with halt=1 SHALL hold the accumulators and the remaining count unchanged; busy stays 1.
REQ-019 The update that brings the remaining count to 0 SHALL move the FSM to DONE; done=1 for exactly that one DONE cycle, then IDLE.
REQ-020 Accumulators SHALL retain their values across runs; a new run continues from the current result.
REQ-021 start SHALL be ignored in RUN and DONE.
REQ-022 clr=1 in any state SHALL zero all accumulators, ovf and the remaining count, and force IDLE next cycle.
REQ-023 clr SHALL take priority over start, halt and a same-cycle completing step; no done pulse is produced.
REQ-024 Signed overflow of a component (operands of equal sign, result of the opposite sign) SHALL set that component's ovf bit, which holds until clr or an accepted start.
REQ-025 A run of count=N with halt held low SHALL take exactly N RUN cycles; done SHALL be asserted on cycle N+1 after acceptance.
REQ-026 result SHALL be registered; no combinational path from any input to result.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and set result=0, busy=0, done=0, ovf=0 and remaining count=0, regardless of clk.
REQ-028 Deassertion of rst_n mid-run SHALL leave the block in IDLE with zeroed accumulators; the interrupted run is not resumed.

Configuration
REQ-029 With macro VEC_STEPPER_SAT_EN defined, an overflowing component SHALL clamp to its signed max (positive overflow) or signed min (negative overflow) and remain clamped at the limit.
REQ-030 Without VEC_STEPPER_SAT_EN, components SHALL wrap modulo 2^CW.
REQ-031 ovf behaviour SHALL be identical in both builds.

Verification
REQ-032 Defaults, step_in={16'd1,16'd3}, count=4 -> after 4 RUN cycles result=32'h0004_000C, done pulse of one cycle, busy low afterwards.
REQ-033 Same run with halt=1 for 3 cycles mid-run -> run takes 7 RUN cycles; final result is unchanged.
REQ-034 Accumulator 0 at 16'h7FFE, step 16'd3, count=1 -> ovf[1]=1 (component 0 is the MSB field); result field 16'h8001 without the macro, 16'h7FFF with it.
REQ-035 clr asserted on the final RUN cycle -> result=0, no done pulse, IDLE next cycle; start with count=0 -> stays IDLE.
REQ-036 rst_n asserted low asynchronously mid-run, between clock edges -> outputs zero before the next edge; NCOMP=4, CW=8 build passes REQ-032 equivalent.
